// File: rtl/rle_channel_arbiter_if.sv
// ---------------------------------------------------------------------------
// rle_channel_arbiter_if
// Bundle between the two capture front-ends, the shared RunLengthEncoder and
// the channel arbiter.
//   req0_* / req1_*  : per-channel byte stream (valid/data/last in, ready out)
//   enc_*            : paced byte, strobe, flush and owner channel to the
//                      encoder; enc_idle back from the encoder
//   busy, timeout_err: arbiter status
// The slave modport is the arbiter's view; master is the environment's view.
// ---------------------------------------------------------------------------
interface rle_channel_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic [7:0] enc_data_in;
    logic       enc_strobe;
    logic       enc_flush;
    logic       enc_chan;
    logic       enc_idle;
    logic       busy;
    logic       timeout_err;

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  enc_idle,
        output req0_ready, req1_ready,
        output enc_data_in, enc_strobe, enc_flush, enc_chan,
        output busy, timeout_err
    );

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output enc_idle,
        input  req0_ready, req1_ready,
        input  enc_data_in, enc_strobe, enc_flush, enc_chan,
        input  busy, timeout_err
    );
endinterface

// File: rtl/rle_channel_arbiter.sv
// ---------------------------------------------------------------------------
// rle_channel_arbiter
// Shares one RunLengthEncoder between two byte-stream requesters. Whole
// packets are granted round-robin; bytes are paced into the encoder with at
// least BYTE_GAP fast_clk cycles between enc_strobe pulses. After a packet's
// last byte the encoder is flushed, and the arbiter waits (bounded by
// FLUSH_TIMEOUT cycles) for enc_idle before arbitrating again.
// Ports:
//   fast_clk : sole clock, rising edge
//   reset    : asynchronous, active-low
//   bus      : rle_channel_arbiter_if.slave (requesters, encoder, status)
// ---------------------------------------------------------------------------
module rle_channel_arbiter #(
    parameter int unsigned BYTE_GAP      = 4,   // 1..15
    parameter int unsigned FLUSH_TIMEOUT = 15   // 1..255
) (
    input  logic                  fast_clk,
    input  logic                  reset,
    rle_channel_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        XFER      = 2'd1,
        FLUSH_GAP = 2'd2,
        WAIT_IDLE = 2'd3
    } state_t;

    localparam logic [3:0] GAP_RELOAD = 4'(BYTE_GAP - 1);
    localparam logic [7:0] WAIT_LIMIT = 8'(FLUSH_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic       grant;
    logic       last_served;
    logic [3:0] gap_cnt;
    logic [7:0] wait_cnt;
    logic [7:0] data_q;
    logic       strobe_q;
    logic       timeout_q;

    logic       sel_valid, sel_last;
    logic [7:0] sel_data;
    logic       any_valid, pick;
    logic       gap_zero, handshake, wait_exit;
    logic       ready0, ready1, flush, busy_o;

    // Mux the granted channel's stream.
    always_comb begin
        sel_valid = bus.req0_valid;
        sel_last  = bus.req0_last;
        sel_data  = bus.req0_data;
        if (grant) begin
            sel_valid = bus.req1_valid;
            sel_last  = bus.req1_last;
            sel_data  = bus.req1_data;
        end
    end

    // Round-robin: on contention the channel not served last wins.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) pick = ~last_served;
        else                                  pick = bus.req1_valid;
    end

    assign gap_zero  = (gap_cnt == '0);
    assign handshake = (state == XFER) && gap_zero && sel_valid;
    // Idle wins over a coinciding timeout; both leave WAIT_IDLE.
    assign wait_exit = bus.enc_idle || (wait_cnt == WAIT_LIMIT);

    // State register
    always_ff @(posedge fast_clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (any_valid)             state_nxt = XFER;
            XFER:      if (handshake && sel_last) state_nxt = FLUSH_GAP;
            FLUSH_GAP: if (gap_zero)              state_nxt = WAIT_IDLE;
            WAIT_IDLE: if (wait_exit)             state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready0 = (state == XFER) && !grant && gap_zero;
        ready1 = (state == XFER) &&  grant && gap_zero;
        flush  = (state == FLUSH_GAP) && gap_zero;
        busy_o = (state != IDLE);
    end

    // Datapath, pacing counter, wait counter and arbitration history.
    always_ff @(posedge fast_clk or negedge reset) begin
        if (!reset) begin
            grant       <= 1'b0;
            last_served <= 1'b1;
            gap_cnt     <= '0;
            wait_cnt    <= '0;
            data_q      <= '0;
            strobe_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            strobe_q <= handshake;
            if (handshake) begin
                data_q  <= sel_data;
                gap_cnt <= GAP_RELOAD;
            end else if (!gap_zero) begin
                gap_cnt <= gap_cnt - 4'd1;
            end

            if (state == IDLE && any_valid) grant <= pick;

            if (state == WAIT_IDLE) begin
                if (wait_exit) begin
                    wait_cnt    <= '0;
                    last_served <= grant;
                    if (!bus.enc_idle) timeout_q <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.enc_data_in = data_q;
    assign bus.enc_strobe  = strobe_q;
    assign bus.enc_flush   = flush;
    assign bus.enc_chan    = grant;
    assign bus.busy        = busy_o;
    assign bus.timeout_err = timeout_q;

endmodule
